interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Receives interrupt requests from the peripherals: timer TIMA overflow, VBlank, LCD STAT, serial and joypad.
- Holds them in the IF (0xFF0F) and IE (0xFFFF) registers.
- Arbitrates by fixed priority and dispatches one vector at a time to the CPU over a request/acknowledge handshake.
- Sits between the peripheral blocks (such as the timer's oInterrupt0x50) and the CPU dispatch logic; also provides a HALT wake-up.

Parameters:
VECTOR_BASE, 8'h40, vector address of source bit 0
VECTOR_STRIDE, 8'h08, address step between consecutive source vectors

Ports:
iClock  in  1  system clock, all state on posedge
iReset_n  in  1  asynchronous active-low reset
iIntVblank  in  1  VBlank request (IF bit 0), rising-edge sensitive
iIntLcdStat  in  1  LCD STAT request (IF bit 1), rising-edge sensitive
iIntTimer  in  1  timer overflow request (IF bit 2), rising-edge sensitive
iIntSerial  in  1  serial request (IF bit 3), rising-edge sensitive
iIntJoypad  in  1  joypad request (IF bit 4), rising-edge sensitive
iMcuWeIf  in  1  CPU write strobe for IF
iMcuWeIe  in  1  CPU write strobe for IE
iMcuWriteData  in  8  CPU write data
iIme  in  1  CPU interrupt master enable
iIrqAck  in  1  CPU accepts the current dispatch (single-cycle pulse)
oIf  out  8  IF readback: {3'b111, rIf[4:0]}
oIe  out  8  IE readback: full 8-bit stored value
oIrqReq  out  1  dispatch request to CPU
oIrqVector  out  8  vector for the pending dispatch; 8'h00 when oIrqReq=0
oWakeup  out  1  HALT exit: any enabled pending request, regardless of IME

Behaviour:
- Reset (async, iReset_n=0):
  - rIf=5'b0, IE=8'h00, all edge-detect flops=0, FSM=IRQ_IDLE.
  - Outputs: oIf=8'hE0, oIe=8'h00, oIrqReq=0, oIrqVector=8'h00, oWakeup=0.
  - Reset mid-dispatch aborts immediately; no IF bit is cleared.
- Edge detection:
  - Each source is registered once; edge[k] = src[k] & ~src_q[k].
  - A level held high sets IF only once.
  - A one-cycle pulse (timer) is caught.
- IF update, priority per bit:
  1. Reset.
  2. Source edge sets the bit.
  3. Ack clear of the serviced bit.
  4. CPU write (iMcuWeIf loads iMcuWriteData[4:0]).
  - An edge coinciding with an ack or a write of 0 on the same bit leaves the bit 1.
  - IF bits 7:5 are not stored.
- IE: loaded from iMcuWriteData on iMcuWeIe, all 8 bits stored.
- Pending: wPend = rIf & IE[4:0].
  - oWakeup = |wPend, combinational from registers.
- Priority encoder: lowest set bit of wPend wins. Vector = VECTOR_BASE + idx*VECTOR_STRIDE, giving 40/48/50/58/60.
- FSM states:
  - IRQ_IDLE:
    - If iIme & |wPend: latch idx into rIdx, go to IRQ_REQ.
  - IRQ_REQ:
    - Outputs: oIrqReq=1, oIrqVector = vector(rIdx). Vector is held stable for the whole state; it is not re-arbitrated even if a higher-priority bit arrives.
    - iIrqAck=1: clear rIf[rIdx], go to IRQ_DONE.
    - Else if ~iIme or ~wPend[rIdx] (CPU cleared IF/IE or IME): cancel, go to IRQ_IDLE. oIrqReq drops next cycle; no IF change.
    - Ack and cancel in the same cycle: ack wins.
  - IRQ_DONE:
    - oIrqReq=0 for exactly one cycle, then IRQ_IDLE. This lets the CPU's IME clear take effect before re-arbitration.
- Latency:
  - Source edge at cycle n → IF bit visible at n+1 → oIrqReq=1 at n+2, when iIme=1 and IE is set.
  - Ack at cycle m → IF bit cleared and oIrqReq=0 at m+1 → earliest next request at m+3.
- iIrqAck outside IRQ_REQ is ignored.
- Outputs are registered or decoded only from registered state; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, IE=8'h04, iIme=1, one-cycle iIntTimer pulse at cycle n → oIf=8'hE4 at n+1; oIrqReq=1 with oIrqVector=8'h50 at n+2. Ack → oIf=8'hE0 and oIrqReq=0 next cycle.
- IE=8'h1F, iIme=1, VBlank and joypad edges in the same cycle → vector 8'h40 first. After ack and IRQ_DONE, vector 8'h60 appears with the joypad bit still set.
- iIme=0, IE=8'h01, VBlank edge → oWakeup=1, oIrqReq stays 0. Raise iIme → oIrqReq=1 with vector 8'h40 the next cycle.
- In IRQ_REQ for the timer, CPU writes IE=8'h00 → oIrqReq=0 next cycle, IF bit 2 remains set, no vector change during the request.
- Ack for the timer coincides with a new iIntTimer edge → IF bit 2 stays 1 and a second 8'h50 dispatch follows. A CPU IF write of 8'h00 coinciding with a serial edge → oIf=8'hE8.
- iIntLcdStat held high for 20 cycles → IF bit 1 set once; after ack it stays 0 until the input falls and rises again. Assert iReset_n=0 asynchronously during IRQ_REQ → outputs at reset values without a clock edge.

Source files
------------

// File: rtl/interrupt_controller.sv
// Edge-latched five-source interrupt controller (IF/IE). Fixed-priority dispatch to the CPU: source edge to oIrqReq in two cycles.
// Request is held with a stable vector until acked or cancelled; a one-cycle gap follows every ack.
module interrupt_controller #(
    parameter logic [7:0] VECTOR_BASE   = 8'h40,
    parameter logic [7:0] VECTOR_STRIDE = 8'h08
) (
    input  logic       iClock,
    input  logic       iReset_n,
    input  logic       iIntVblank,
    input  logic       iIntLcdStat,
    input  logic       iIntTimer,
    input  logic       iIntSerial,
    input  logic       iIntJoypad,
    input  logic       iMcuWeIf,
    input  logic       iMcuWeIe,
    input  logic [7:0] iMcuWriteData,
    input  logic       iIme,
    input  logic       iIrqAck,
    output logic [7:0] oIf,
    output logic [7:0] oIe,
    output logic       oIrqReq,
    output logic [7:0] oIrqVector,
    output logic       oWakeup
);

    typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_DONE} irq_state_e;

    irq_state_e state_q, state_d;
    logic [4:0] if_q, if_d;
    logic [7:0] ie_q, ie_d;
    logic [4:0] src_q;
    logic [2:0] idx_q, idx_d;
    logic [4:0] src, src_edge, pend, sel_mask;
    logic [2:0] enc_idx;
    logic       ack_clr;

    assign src      = {iIntJoypad, iIntSerial, iIntTimer, iIntLcdStat, iIntVblank};
    assign src_edge = src & ~src_q;
    assign pend     = if_q & ie_q[4:0];
    assign sel_mask = 5'b00001 << idx_q;
    assign ack_clr  = (state_q == IRQ_REQ) && iIrqAck;

    always_comb begin
        enc_idx = 3'd0;
        for (int k = 4; k >= 0; k--) begin
            if (pend[k]) enc_idx = 3'(k);
        end
    end

    // Later assignments win: a source edge overrides both the ack clear and a CPU write.
    always_comb begin
        if_d = if_q;
        if (iMcuWeIf) if_d = iMcuWriteData[4:0];
        if (ack_clr)  if_d = if_d & ~sel_mask;
        if_d = if_d | src_edge;
    end

    assign ie_d = iMcuWeIe ? iMcuWriteData : ie_q;

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            if_q  <= 5'd0;
            ie_q  <= 8'h00;
            src_q <= 5'd0;
            idx_q <= 3'd0;
        end else begin
            if_q  <= if_d;
            ie_q  <= ie_d;
            src_q <= src;
            idx_q <= idx_d;
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) state_q <= IRQ_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IRQ_IDLE: begin
                if (iIme && (|pend)) begin
                    state_d = IRQ_REQ;
                    idx_d   = enc_idx;
                end
            end
            IRQ_REQ: begin
                if (iIrqAck)                              state_d = IRQ_DONE;
                else if (!iIme || !(|(pend & sel_mask)))  state_d = IRQ_IDLE;
            end
            IRQ_DONE: state_d = IRQ_IDLE;
            default:  state_d = IRQ_IDLE;
        endcase
    end

    always_comb begin
        oIrqReq    = 1'b0;
        oIrqVector = 8'h00;
        if (state_q == IRQ_REQ) begin
            oIrqReq    = 1'b1;
            oIrqVector = VECTOR_BASE + ({5'd0, idx_q} * VECTOR_STRIDE);
        end
    end

    assign oIf     = {3'b111, if_q};
    assign oIe     = ie_q;
    assign oWakeup = |pend;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench: expected dispatch vectors are queued at stimulus time and checked by a negedge monitor.
module tb_interrupt_controller;

    logic       iClock = 1'b0;
    logic       iReset_n;
    logic       iIntVblank, iIntLcdStat, iIntTimer, iIntSerial, iIntJoypad;
    logic       iMcuWeIf, iMcuWeIe;
    logic [7:0] iMcuWriteData;
    logic       iIme, iIrqAck;
    logic [7:0] oIf, oIe, oIrqVector;
    logic       oIrqReq, oWakeup;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cur_vec = 8'h00;
    logic       req_prev = 1'b0;

    interrupt_controller dut (
        .iClock        (iClock),
        .iReset_n      (iReset_n),
        .iIntVblank    (iIntVblank),
        .iIntLcdStat   (iIntLcdStat),
        .iIntTimer     (iIntTimer),
        .iIntSerial    (iIntSerial),
        .iIntJoypad    (iIntJoypad),
        .iMcuWeIf      (iMcuWeIf),
        .iMcuWeIe      (iMcuWeIe),
        .iMcuWriteData (iMcuWriteData),
        .iIme          (iIme),
        .iIrqAck       (iIrqAck),
        .oIf           (oIf),
        .oIe           (oIe),
        .oIrqReq       (oIrqReq),
        .oIrqVector    (oIrqVector),
        .oWakeup       (oWakeup)
    );

    always #5 iClock = ~iClock;

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
        end
    endtask

    task automatic wr_ie(input logic [7:0] v);
        iMcuWeIe = 1'b1;
        iMcuWriteData = v;
        tick();
        iMcuWeIe = 1'b0;
    endtask

    task automatic wr_if(input logic [7:0] v);
        iMcuWeIf = 1'b1;
        iMcuWriteData = v;
        tick();
        iMcuWeIf = 1'b0;
    endtask

    task automatic ack();
        iIrqAck = 1'b1;
        tick();
        iIrqAck = 1'b0;
    endtask

    // Dispatch monitor: pops an expected vector on every rising oIrqReq.
    initial begin
        forever begin
            @(negedge iClock);
            if (!iReset_n) begin
                req_prev = 1'b0;
            end else begin
                checks++;
                if (oIrqReq && !req_prev) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_dispatch: got vector %02h, none expected", oIrqVector);
                    end else begin
                        cur_vec = exp_q.pop_front();
                        if (oIrqVector !== cur_vec) begin
                            errors++;
                            $display("FAIL dispatch_vector: got %02h, expected %02h", oIrqVector, cur_vec);
                        end
                    end
                end else if (oIrqReq) begin
                    if (oIrqVector !== cur_vec) begin
                        errors++;
                        $display("FAIL vector_stable: got %02h, expected %02h", oIrqVector, cur_vec);
                    end
                end else if (oIrqVector !== 8'h00) begin
                    errors++;
                    $display("FAIL idle_vector: got %02h, expected 00", oIrqVector);
                end
                req_prev = oIrqReq;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        iReset_n = 1'b0;
        {iIntVblank, iIntLcdStat, iIntTimer, iIntSerial, iIntJoypad} = 5'b0;
        iMcuWeIf = 1'b0; iMcuWeIe = 1'b0; iMcuWriteData = 8'h00;
        iIme = 1'b0; iIrqAck = 1'b0;
        tick();
        tick();
        chk("rst_if", oIf, 8'hE0);
        chk("rst_ie", oIe, 8'h00);
        chk("rst_req", {7'd0, oIrqReq}, 8'h00);
        chk("rst_vec", oIrqVector, 8'h00);
        chk("rst_wake", {7'd0, oWakeup}, 8'h00);
        iReset_n = 1'b1;
        tick();

        // Timer pulse: IF at n+1, request at n+2, ack clears
        wr_ie(8'h04);
        chk("ie_readback", oIe, 8'h04);
        iIme = 1'b1;
        iIntTimer = 1'b1; exp_q.push_back(8'h50);
        tick();
        chk("t1_if_set", oIf, 8'hE4);
        chk("t1_req_n1", {7'd0, oIrqReq}, 8'h00);
        iIntTimer = 1'b0;
        tick();
        chk("t1_req_n2", {7'd0, oIrqReq}, 8'h01);
        chk("t1_vec", oIrqVector, 8'h50);
        ack();
        chk("t1_if_clr", oIf, 8'hE0);
        chk("t1_req_drop", {7'd0, oIrqReq}, 8'h00);
        tick();

        // Simultaneous VBlank + joypad: 40 first, then 60 at m+3
        wr_ie(8'h1F);
        iIntVblank = 1'b1; iIntJoypad = 1'b1;
        exp_q.push_back(8'h40); exp_q.push_back(8'h60);
        tick();
        chk("t2_if_both", oIf, 8'hF1);
        iIntVblank = 1'b0; iIntJoypad = 1'b0;
        tick();
        chk("t2_vec_first", oIrqVector, 8'h40);
        ack();
        chk("t2_if_after_ack", oIf, 8'hF0);
        chk("t2_req_done", {7'd0, oIrqReq}, 8'h00);
        tick();
        chk("t2_req_idle", {7'd0, oIrqReq}, 8'h00);
        tick();
        chk("t2_req_second", {7'd0, oIrqReq}, 8'h01);
        chk("t2_vec_second", oIrqVector, 8'h60);
        chk("t2_joy_pending", oIf, 8'hF0);
        ack();
        chk("t2_if_clr", oIf, 8'hE0);
        tick();

        // IME low: wake-up without dispatch, then IME raise dispatches next cycle
        iIme = 1'b0;
        wr_ie(8'h01);
        iIntVblank = 1'b1;
        tick();
        chk("t3_if", oIf, 8'hE1);
        chk("t3_wake", {7'd0, oWakeup}, 8'h01);
        iIntVblank = 1'b0;
        tick();
        tick();
        chk("t3_no_req", {7'd0, oIrqReq}, 8'h00);
        exp_q.push_back(8'h40);
        iIme = 1'b1;
        tick();
        chk("t3_req_ime", {7'd0, oIrqReq}, 8'h01);
        chk("t3_vec", oIrqVector, 8'h40);
        ack();
        chk("t3_wake_clr", {7'd0, oWakeup}, 8'h00);
        tick();

        // Cancel by IE write during request
        wr_ie(8'h04);
        iIntTimer = 1'b1; exp_q.push_back(8'h50);
        tick();
        iIntTimer = 1'b0;
        tick();
        chk("t4_req", {7'd0, oIrqReq}, 8'h01);
        wr_ie(8'h00);
        tick();
        chk("t4_cancel", {7'd0, oIrqReq}, 8'h00);
        chk("t4_if_kept", oIf, 8'hE4);
        chk("t4_ie", oIe, 8'h00);
        wr_if(8'h00);
        chk("t4_if_wr", oIf, 8'hE0);

        // Ack coinciding with new timer edge keeps bit and re-dispatches
        wr_ie(8'h04);
        iIntTimer = 1'b1; exp_q.push_back(8'h50);
        tick();
        iIntTimer = 1'b0;
        tick();
        chk("t5_req", {7'd0, oIrqReq}, 8'h01);
        iIrqAck = 1'b1; iIntTimer = 1'b1; exp_q.push_back(8'h50);
        tick();
        iIrqAck = 1'b0; iIntTimer = 1'b0;
        chk("t5_if_kept", oIf, 8'hE4);
        chk("t5_req_done", {7'd0, oIrqReq}, 8'h00);
        tick();
        tick();
        chk("t5_req_again", {7'd0, oIrqReq}, 8'h01);
        chk("t5_vec_again", oIrqVector, 8'h50);
        ack();
        chk("t5_if_clr", oIf, 8'hE0);
        iMcuWeIf = 1'b1; iMcuWriteData = 8'h00; iIntSerial = 1'b1;
        tick();
        iMcuWeIf = 1'b0; iIntSerial = 1'b0;
        chk("t5_serial_wins", oIf, 8'hE8);
        wr_if(8'h00);
        tick();

        // LCD STAT held high sets IF once
        wr_ie(8'h02);
        iIntLcdStat = 1'b1; exp_q.push_back(8'h48);
        tick();
        chk("t6_if", oIf, 8'hE2);
        tick();
        chk("t6_vec", oIrqVector, 8'h48);
        ack();
        chk("t6_if_clr", oIf, 8'hE0);
        for (int i = 0; i < 17; i++) tick();
        chk("t6_held_if", oIf, 8'hE0);
        chk("t6_held_req", {7'd0, oIrqReq}, 8'h00);
        iIntLcdStat = 1'b0;
        tick();
        iIntLcdStat = 1'b1; exp_q.push_back(8'h48);
        tick();
        chk("t6_reedge_if", oIf, 8'hE2);
        iIntLcdStat = 1'b0;
        tick();
        chk("t6_req", {7'd0, oIrqReq}, 8'h01);
        @(negedge iClock);
        #2;
        iReset_n = 1'b0;
        #1;
        chk("arst_if", oIf, 8'hE0);
        chk("arst_ie", oIe, 8'h00);
        chk("arst_req", {7'd0, oIrqReq}, 8'h00);
        chk("arst_vec", oIrqVector, 8'h00);
        chk("arst_wake", {7'd0, oWakeup}, 8'h00);
        tick();
        iReset_n = 1'b1;
        tick();
        tick();
        chk("leftover_dispatches", 8'(exp_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
